// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding,
// default sizing constants and the row-count helper.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam int DEFAULT_N_VARS = 3;
    localparam int DEFAULT_SETTLE = 1;

    // Number of truth-table rows for an n-input function.
    function automatic int row_count(input int n_vars);
        return 1 << n_vars;
    endfunction

endpackage

// File: rtl/tt_popcount.sv
// Parameterised population count: number of set bits in a WIDTH-bit vector.
module tt_popcount
    import tt_pkg::*;
#(
    parameter int WIDTH   = row_count(DEFAULT_N_VARS),
    parameter int COUNT_W = DEFAULT_N_VARS + 1
) (
    input  logic [WIDTH-1:0]   bits,
    output logic [COUNT_W-1:0] count
);

    // Sum the individual bits; a plain adder chain is fine at table widths.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + COUNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every input row of an N_VARS-input function,
// holds each row SETTLE extra cycles, and captures the function output into
// a minterm mask with a ones count.
// Optional feature macro: TT_COMPARE_EN builds the comparator against
// 'expected'; without it 'match' is tied low and 'expected' is ignored.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_VARS = DEFAULT_N_VARS,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [N_VARS-1:0]              vars_out,
    input  logic                           f_in,
    input  logic [row_count(N_VARS)-1:0]   expected,
    output logic                           busy,
    output logic                           done,
    output logic [row_count(N_VARS)-1:0]   minterms,
    output logic [N_VARS:0]                ones_count,
    output logic                           match
);

    localparam int ROWS = row_count(N_VARS);
    localparam logic [N_VARS-1:0] LAST_ROW = '1;
    // Settle counter runs 0..SETTLE-1 while in DRIVE.
    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    // With no settle time a row goes straight to capture.
    localparam state_t ROW_ENTRY = (SETTLE > 0) ? DRIVE : SAMPLE;

    state_t            state;
    state_t            state_next;
    logic [N_VARS-1:0] row;
    logic [3:0]        settle_cnt;
    logic              clear_sweep;
    logic              capture;
    logic              advance;
    logic              settle_inc;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the control strobes and decoded outputs.
    always_comb begin
        state_next  = state;
        clear_sweep = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        settle_inc  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        vars_out    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_sweep = 1'b1;
                    state_next  = ROW_ENTRY;
                end
            end
            DRIVE: begin
                busy     = 1'b1;
                vars_out = row;
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end else begin
                    settle_inc = 1'b1;
                end
            end
            SAMPLE: begin
                busy     = 1'b1;
                vars_out = row;
                capture  = 1'b1;
                if (row == LAST_ROW) begin
                    state_next = DONE;
                end else begin
                    advance    = 1'b1;
                    state_next = ROW_ENTRY;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Row index, settle counter and the captured minterm mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            row        <= '0;
            settle_cnt <= '0;
            minterms   <= '0;
        end else begin
            settle_cnt <= settle_inc ? settle_cnt + 4'd1 : 4'd0;
            if (clear_sweep) begin
                minterms <= '0;
                row      <= '0;
            end
            if (capture) begin
                minterms[row] <= f_in;
            end
            if (advance) begin
                row <= row + 1'b1;
            end
        end
    end

    tt_popcount #(
        .WIDTH   (ROWS),
        .COUNT_W (N_VARS + 1)
    ) u_popcount (
        .bits  (minterms),
        .count (ones_count)
    );

`ifdef TT_COMPARE_EN
    assign match = (minterms == expected);
`else
    logic unused_expected;
    assign unused_expected = ^expected;
    assign match = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default instance (N_VARS=3,
// SETTLE=1) plus a SETTLE=3 instance sweeping x&y&z.
module tb_truth_table_sweeper;

`ifdef TT_COMPARE_EN
    localparam logic CMP = 1'b1;
`else
    localparam logic CMP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic       start3;
    int         f_sel;
    logic [2:0] vars_out;
    logic       f_in;
    logic [7:0] expected;
    logic       busy;
    logic       done;
    logic [7:0] minterms;
    logic [3:0] ones_count;
    logic       match;

    logic [2:0] vars_out3;
    logic       f_in3;
    logic [7:0] expected3;
    logic       busy3;
    logic       done3;
    logic [7:0] minterms3;
    logic [3:0] ones_count3;
    logic       match3;

    int total;
    int bad;

    truth_table_sweeper #(.N_VARS(3), .SETTLE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .vars_out   (vars_out),
        .f_in       (f_in),
        .expected   (expected),
        .busy       (busy),
        .done       (done),
        .minterms   (minterms),
        .ones_count (ones_count),
        .match      (match)
    );

    truth_table_sweeper #(.N_VARS(3), .SETTLE(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .start      (start3),
        .vars_out   (vars_out3),
        .f_in       (f_in3),
        .expected   (expected3),
        .busy       (busy3),
        .done       (done3),
        .minterms   (minterms3),
        .ones_count (ones_count3),
        .match      (match3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Functions under test, x = vars[2], y = vars[1], z = vars[0].
    always_comb begin
        case (f_sel)
            0:       f_in = 1'b0;
            1:       f_in = 1'b1;
            2:       f_in = vars_out[2] ^ vars_out[1];
            3:       f_in = (~vars_out[2] | vars_out[1]) & (vars_out[1] | vars_out[0]);
            4:       f_in = vars_out[2] | vars_out[1];
            default: f_in = 1'b0;
        endcase
    end

    assign f_in3     = vars_out3[2] & vars_out3[1] & vars_out3[0];
    assign expected3 = 8'h80;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then wait (bounded) for done; edges counts
    // the edges after the start edge until done is first seen high.
    task automatic sweep(input string tag, output int edges);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_cleared_at_start"}, minterms, 0);
        edges = 0;
        while (done !== 1'b1 && edges < 200) begin
            step();
            edges++;
        end
        chk({tag, "_done_seen"}, done, 1);
    endtask

    task automatic wait_row(input string tag, input logic [2:0] r);
        int n;
        n = 0;
        while (vars_out !== r && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_row_reached"}, vars_out, r);
    endtask

    initial begin
        int edges;
        int extra;
        int seen_done;
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        start3   = 1'b0;
        f_sel    = 0;
        expected = 8'h00;
        step();
        step();

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vars", vars_out, 0);
        chk("rst_minterms", minterms, 0);
        chk("rst_ones", ones_count, 0);
        chk("rst_match", match, CMP);
        chk("rst_busy3", busy3, 0);
        reset = 1'b0;

        // start and reset together: reset wins
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_wins_busy", busy, 0);
        step();
        chk("rst_wins_busy_later", busy, 0);

        // f = x^y with defaults
        f_sel    = 2;
        expected = 8'h3C;
        sweep("xor", edges);
        chk("xor_done_edge", edges, 16);
        chk("xor_minterms", minterms, 8'h3C);
        chk("xor_ones", ones_count, 4);
        chk("xor_busy_in_done", busy, 0);
        chk("xor_match", match, CMP);
        step();
        chk("xor_done_one_cycle", done, 0);
        step();
        step();
        chk("xor_hold", minterms, 8'h3C);

        // f = (~x|y)&(y|z)
        f_sel    = 3;
        expected = 8'hCE;
        sweep("pos", edges);
        chk("pos_minterms", minterms, 8'hCE);
        chk("pos_ones", ones_count, 5);
        chk("pos_match", match, CMP);
        step();

        // f = 0 then f = 1
        f_sel    = 0;
        expected = 8'h00;
        sweep("zero", edges);
        chk("zero_minterms", minterms, 8'h00);
        chk("zero_ones", ones_count, 0);
        chk("zero_match", match, CMP);
        step();
        f_sel    = 1;
        expected = 8'h00;
        sweep("one", edges);
        chk("one_minterms", minterms, 8'hFF);
        chk("one_ones", ones_count, 8);
        chk("one_match", match, 0);
        step();
        f_sel = 0;
        sweep("zero_again", edges);
        chk("zero_again_minterms", minterms, 8'h00);
        step();

        // SETTLE=3 instance, x&y&z: each row held 4 cycles
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        chk("s3_busy", busy3, 1);
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                chk("s3_vars_row", vars_out3, r);
                step();
            end
        end
        chk("s3_done_at_33", done3, 1);
        chk("s3_minterms", minterms3, 8'h80);
        chk("s3_ones", ones_count3, 1);
        chk("s3_match", match3, CMP);
        step();
        chk("s3_done_pulse", done3, 0);

        // reset at row 4
        f_sel    = 2;
        expected = 8'h3C;
        start    = 1'b1;
        step();
        start    = 1'b0;
        wait_row("rstmid", 3'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_minterms", minterms, 0);
        chk("rstmid_vars", vars_out, 0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) seen_done++;
            step();
        end
        chk("rstmid_no_done", seen_done, 0);
        sweep("after_rst", edges);
        chk("after_rst_minterms", minterms, 8'h3C);
        chk("after_rst_edges", edges, 16);
        step();

        // extra start at row 2 is ignored; f = x|y against expected 3C
        f_sel    = 4;
        expected = 8'h3C;
        start    = 1'b1;
        step();
        start    = 1'b0;
        wait_row("restart", 3'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        edges = 0;
        while (done !== 1'b1 && edges < 200) begin
            step();
            edges++;
        end
        chk("restart_done_seen", done, 1);
        chk("restart_minterms", minterms, 8'hFC);
        chk("restart_ones", ones_count, 6);
        chk("restart_match", match, 0);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        chk("restart_single_done", extra, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
